key_cmd_decoder: RTL

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

---
 rtl/key_cmd_pkg.sv | 64 ++++++
 rtl/key_pulse_stretch.sv | 49 ++++
 rtl/key_cmd_decoder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg: shared definitions for the keyboard command decoder.
//   - PS/2 set-2 scancode constants (prefixes, command keys, digits 0..9)
//   - cmd_t command enum driven into the pulse stretcher
//   - run_state_t run/stop FSM encoding
//   - decode_digit(): maps a make code to {valid, value}
package key_cmd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_PAUSE = 8'h4D;
    localparam logic [7:0] SC_CLEAR = 8'h2D;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_START = 2'd1,
        CMD_PAUSE = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } digit_t;

    // Translate a digit make code into its decimal value.
    function automatic digit_t decode_digit(input logic [7:0] sc);
        digit_t d;
        d.valid = 1'b1;
        d.value = 4'd0;
        case (sc)
            SC_D0:   d.value = 4'd0;
            SC_D1:   d.value = 4'd1;
            SC_D2:   d.value = 4'd2;
            SC_D3:   d.value = 4'd3;
            SC_D4:   d.value = 4'd4;
            SC_D5:   d.value = 4'd5;
            SC_D6:   d.value = 4'd6;
            SC_D7:   d.value = 4'd7;
            SC_D8:   d.value = 4'd8;
            SC_D9:   d.value = 4'd9;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_pulse_stretch.sv
// key_pulse_stretch: turns a one-cycle command into a one-hot output pulse
// lasting exactly PULSE_CYCLES cycles. A new command drops the previous
// output and reloads the counter on the same edge.
//   clk_in, reset (async, active-high)
//   cmd                 : command this cycle (CMD_NONE = nothing)
//   start, pause, clear : registered one-hot stretched pulses
module key_pulse_stretch
    import key_cmd_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 65536
) (
    input  logic clk_in,
    input  logic reset,
    input  cmd_t cmd,
    output logic start,
    output logic pause,
    output logic clear
);

    localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // count holds the remaining high cycles including the current one;
    // outputs drop on the edge where it reaches zero.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count <= '0;
            start <= 1'b0;
            pause <= 1'b0;
            clear <= 1'b0;
        end else if (cmd != CMD_NONE) begin
            count <= CNT_LOAD;
            start <= (cmd == CMD_START);
            pause <= (cmd == CMD_PAUSE);
            clear <= (cmd == CMD_CLEAR);
        end else if (count != '0) begin
            count <= count - CNT_ONE;
            if (count == CNT_ONE) begin
                start <= 1'b0;
                pause <= 1'b0;
                clear <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder: decodes PS/2 set-2 scancodes into playback commands.
// Digits build a decimal file index, Enter commits it and starts, P pauses,
// R clears, Esc discards the pending entry. F0/E0 prefixes are tracked.
//   clk_in, reset (async, active-high)
//   scancode[7:0], scancode_valid : receiver byte + one-cycle qualifier
//   start, pause, clear           : stretched command pulses
//   running                       : run/stop state
//   file_id[ID_WIDTH-1:0]         : committed pattern index
//   digit_count[2:0]              : digits held in the pending entry
// Optional: define KEY_CMD_REPEAT_FILTER_EN to suppress typematic repeats.
module key_cmd_decoder
    import key_cmd_pkg::*;
#(
    parameter int unsigned ID_WIDTH     = 16,
    parameter int unsigned MAX_DIGITS   = 3,
    parameter int unsigned PULSE_CYCLES = 65536
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [7:0]          scancode,
    input  logic                scancode_valid,
    output logic                start,
    output logic                pause,
    output logic                clear,
    output logic                running,
    output logic [ID_WIDTH-1:0] file_id,
    output logic [2:0]          digit_count
);

    localparam int unsigned WIDE_W = ID_WIDTH + 4;
    localparam logic [ID_WIDTH-1:0] ID_MAX = '1;

    run_state_t          state, state_nxt;
    cmd_t                cmd_c;
    logic                break_pending, ext_pending;
    logic                break_nxt, ext_nxt;
    logic                key_c, repeat_c, hit_c;
    logic                ev_digit, ev_esc, ev_enter, ev_pause, ev_clear;
    logic                digit_room_c;
    digit_t              dig_c;
    logic [ID_WIDTH-1:0] entry;
    logic [WIDE_W-1:0]   entry_mac_c;
    logic [ID_WIDTH-1:0] entry_sat_c;

    // Prefix tracking: decide whether this byte is a key to decode.
    always_comb begin
        key_c     = 1'b0;
        break_nxt = break_pending;
        ext_nxt   = ext_pending;
        if (scancode_valid) begin
            if (break_pending) begin
                break_nxt = 1'b0;
            end else if (ext_pending) begin
                ext_nxt = 1'b0;
                key_c   = (scancode == SC_ENTER);
            end else if (scancode == SC_BREAK) begin
                break_nxt = 1'b1;
            end else if (scancode == SC_EXT) begin
                ext_nxt = 1'b1;
            end else begin
                key_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
        end else begin
            break_pending <= break_nxt;
            ext_pending   <= ext_nxt;
        end
    end

`ifdef KEY_CMD_REPEAT_FILTER_EN
    logic [7:0] last_make;
    logic       last_armed;

    // A make equal to the last one with no break in between is a typematic repeat.
    assign repeat_c = key_c && last_armed && (scancode == last_make);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            last_make  <= 8'h00;
            last_armed <= 1'b0;
        end else if (key_c) begin
            last_make  <= scancode;
            last_armed <= 1'b1;
        end else if (scancode_valid && break_pending && (scancode == last_make)) begin
            last_armed <= 1'b0;
        end
    end
`else
    assign repeat_c = 1'b0;
`endif

    // Key events (before run-state qualification).
    assign hit_c    = key_c & ~repeat_c;
    assign dig_c    = decode_digit(scancode);
    assign ev_digit = hit_c & dig_c.valid;
    assign ev_esc   = hit_c & (scancode == SC_ESC);
    assign ev_enter = hit_c & (scancode == SC_ENTER);
    assign ev_pause = hit_c & (scancode == SC_PAUSE);
    assign ev_clear = hit_c & (scancode == SC_CLEAR);

    // Run/stop FSM: state register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run/stop FSM: next state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ev_enter) state_nxt = ST_RUN;
            ST_RUN:  if (ev_pause || ev_clear) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Run/stop FSM: command issued to the pulse stretcher.
    always_comb begin
        cmd_c = CMD_NONE;
        if (ev_clear) begin
            cmd_c = CMD_CLEAR;
        end else if ((state == ST_IDLE) && ev_enter) begin
            cmd_c = CMD_START;
        end else if ((state == ST_RUN) && ev_pause) begin
            cmd_c = CMD_PAUSE;
        end
    end

    assign running = (state == ST_RUN);

    // entry*10+d in a wider word; 10*(2^W-1)+9 < 2^(W+4) so nothing is lost.
    assign entry_mac_c  = WIDE_W'(entry) * WIDE_W'(10) + WIDE_W'(dig_c.value);
    assign entry_sat_c  = (entry_mac_c > WIDE_W'(ID_MAX)) ? ID_MAX : entry_mac_c[ID_WIDTH-1:0];
    assign digit_room_c = (digit_count < 3'(MAX_DIGITS));

    // Digit entry and committed file index.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            entry       <= '0;
            digit_count <= 3'd0;
            file_id     <= '0;
        end else if (ev_clear || ev_esc) begin
            entry       <= '0;
            digit_count <= 3'd0;
        end else if (ev_enter && (state == ST_IDLE)) begin
            if (digit_count != 3'd0) begin
                file_id <= entry;
            end
            entry       <= '0;
            digit_count <= 3'd0;
        end else if (ev_digit && (state == ST_IDLE) && digit_room_c) begin
            entry       <= entry_sat_c;
            digit_count <= digit_count + 3'd1;
        end
    end

    key_pulse_stretch #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse (
        .clk_in (clk_in),
        .reset  (reset),
        .cmd    (cmd_c),
        .start  (start),
        .pause  (pause),
        .clear  (clear)
    );

endmodule
